// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Sends one command byte to the device over the shared open-collector ps2_clk/ps2_data lines.
// The block only ever pulls a line low (oe=1) or releases it (oe=0).
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,    // clk cycles ps2_clk is held low before request-to-send
  parameter int TIMEOUT_CYCLES = 375000,  // max clk cycles between device clock falls / for final idle
  parameter int CNT_W          = 19       // shared timer width, holds max(INHIBIT_CYCLES, TIMEOUT_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_BITS,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  // Pad synchronisers; idle lines read high, so reset to 1 to avoid a false fall after reset
  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_data_s1, r_data_s2;

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic [3:0]       r_bit_idx;
  logic [7:0]       r_byte;
  logic             r_par;
  logic             r_clk_oe;
  logic             r_data_oe;
  logic             r_tx_ready;
  logic             r_tx_done;
  logic             r_tx_error;

  logic w_fall;
  logic w_timeout;

  // Two-flop synchronisers plus one delayed copy of ps2_clk for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_data_s1  <= 1'b1;
      r_data_s2  <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_data_s1  <= ps2_data_in;
      r_data_s2  <= r_data_s1;
    end
  end

  assign w_fall    = r_clk_prev & ~r_clk_s2;
  assign w_timeout = (r_timer == TMO_LAST);

  // Transmit FSM; the timer restarts on every state entry and every device clock fall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_bit_idx  <= '0;
      r_byte     <= '0;
      r_par      <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_tx_ready <= 1'b1;
      r_tx_done  <= 1'b0;
      r_tx_error <= 1'b0;
    end else begin
      r_tx_done  <= 1'b0;
      r_tx_error <= 1'b0;
      r_timer    <= r_timer + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_timer    <= '0;
          r_clk_oe   <= 1'b0;
          r_data_oe  <= 1'b0;
          r_tx_ready <= 1'b1;
          if (tx_valid) begin
            r_byte     <= tx_data;
            r_par      <= ~^tx_data;   // odd parity over data + parity bit
            r_clk_oe   <= 1'b1;        // begin inhibit: hold ps2_clk low
            r_tx_ready <= 1'b0;
            r_state    <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (r_timer == INH_LAST) begin
            r_data_oe <= 1'b1;         // start bit while clock is still held
            r_timer   <= '0;
            r_state   <= S_REQ;
          end
        end

        S_REQ: begin
          r_clk_oe  <= 1'b0;           // release clock: device now generates it
          r_bit_idx <= '0;
          r_timer   <= '0;
          r_state   <= S_BITS;
        end

        S_BITS: begin
          if (w_fall) begin
            r_timer   <= '0;
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx < 4'd8) begin
              r_data_oe <= ~r_byte[r_bit_idx[2:0]];
            end else if (r_bit_idx == 4'd8) begin
              r_data_oe <= ~r_par;
            end else begin
              r_data_oe <= 1'b0;       // stop bit: release data, device will ACK
              r_state   <= S_ACK;
            end
          end else if (w_timeout) begin
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_tx_error <= 1'b1;
            r_tx_ready <= 1'b1;
            r_timer    <= '0;
            r_state    <= S_IDLE;
          end
        end

        S_ACK: begin
          if (w_fall) begin
            r_timer <= '0;
            if (!r_data_s2) begin
              r_state <= S_WAIT_IDLE;
            end else begin
              r_tx_error <= 1'b1;      // device did not acknowledge
              r_tx_ready <= 1'b1;
              r_state    <= S_IDLE;
            end
          end else if (w_timeout) begin
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_tx_error <= 1'b1;
            r_tx_ready <= 1'b1;
            r_timer    <= '0;
            r_state    <= S_IDLE;
          end
        end

        S_WAIT_IDLE: begin
          if (r_clk_s2 && r_data_s2) begin
            r_tx_done  <= 1'b1;
            r_tx_ready <= 1'b1;
            r_timer    <= '0;
            r_state    <= S_IDLE;
          end else if (w_timeout) begin
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_tx_error <= 1'b1;
            r_tx_ready <= 1'b1;
            r_timer    <= '0;
            r_state    <= S_IDLE;
          end
        end

        default: begin
          r_clk_oe   <= 1'b0;
          r_data_oe  <= 1'b0;
          r_tx_ready <= 1'b1;
          r_timer    <= '0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign tx_ready    = r_tx_ready;
  assign busy        = ~r_tx_ready;
  assign tx_done     = r_tx_done;
  assign tx_error    = r_tx_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a simple PS/2 device model and checks every
// transmitted frame against a frame built from the byte (start, LSB-first data, odd parity, stop).
// Timing parameters are scaled down so the whole run stays short.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int TMO = 400;
  localparam int CW  = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ps2_clk_oe, ps2_data_oe, tx_ready, busy, tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       pad_clk, pad_data;

  // Open-collector wired-AND of host and device on both lines
  assign pad_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign pad_data = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk_in(pad_clk),
    .ps2_data_in(pad_data),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .tx_done(tx_done),
    .tx_error(tx_error)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;
  int n_err    = 0;
  int n_frames = 0;
  int inh_cnt  = 0;
  int inh_len  = -1;
  int rel_cyc  = 0;
  int err_cyc  = 0;
  logic prev_clk_oe  = 1'b0;
  logic prev_data_oe = 1'b0;

  logic [10:0] dev_bits = '1;
  int          dev_idx  = -1;
  bit          dev_abort = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1 (index 0 = first bit on the wire)
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      if (b[i]) ones++;
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Per-cycle compare process: interface rules that must hold on every cycle out of reset
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("busy_vs_ready", busy, !tx_ready);
      check("done_err_excl", tx_done & tx_error, 0);
      if (tx_ready) check("idle_released", {ps2_clk_oe, ps2_data_oe}, 0);
      if (tx_done) n_done++;
      if (tx_error) begin
        n_err++;
        err_cyc = cyc;
      end
      if (ps2_clk_oe && !prev_clk_oe) n_frames++;
      if (!ps2_clk_oe && prev_clk_oe) rel_cyc = cyc;
      if (ps2_clk_oe && !ps2_data_oe) inh_cnt++;
      else if (ps2_clk_oe && ps2_data_oe && !prev_data_oe) inh_len = inh_cnt;
      if (!ps2_clk_oe) inh_cnt = 0;
    end
    prev_clk_oe  = ps2_clk_oe;
    prev_data_oe = ps2_data_oe;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("ready_drop", tx_ready, 0);
  endtask

  task automatic dwait(input int n);
    for (int k = 0; k < n; k++) begin
      if (dev_abort) break;
      @(negedge clk);
    end
  endtask

  // Device model. mode 0: normal with ACK, 1: never clocks, 2: no ACK.
  // Samples the line while ps2_clk is high before each fall (the device's rising-edge sample).
  task automatic device(input int mode, input int h);
    int guard;
    guard    = 0;
    dev_idx  = -1;
    dev_bits = '1;
    while (!(pad_clk && !pad_data) && guard < 4 * INH + 100) begin
      @(negedge clk);
      guard++;
    end
    check("rts_seen", pad_clk && !pad_data, 1);
    if (mode == 1 || !(pad_clk && !pad_data)) return;
    dwait($urandom_range(5, 20));
    for (int i = 0; i < 11; i++) begin
      if (dev_abort) break;
      dev_bits[i] = pad_data;
      dev_idx = i;
      if (i == 10) begin
        dev_data_low = (mode != 2);
        dwait(2);
      end
      dev_clk_low = 1'b1;
      dwait(h);
      dev_clk_low = 1'b0;
      dwait(h);
    end
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int bound);
    int k;
    k = 0;
    while (!tx_ready && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(name, tx_ready, 1);
  endtask

  task automatic run_frame(input logic [7:0] b, input int mode);
    int h, d0, e0;
    h  = $urandom_range(15, 30);
    d0 = n_done;
    e0 = n_err;
    inh_len = -1;
    fork
      send_byte(b);
      device(mode, h);
    join
    wait_ready("ready_back", TMO + 200);
    repeat (2) @(negedge clk);
    if (mode == 0) begin
      check("frame_bits", dev_bits, model_frame(b));
      check("inhibit_len", inh_len, INH);
      check("done_once", n_done - d0, 1);
      check("no_error", n_err - e0, 0);
    end else if (mode == 1) begin
      check("timeout_delay", err_cyc - rel_cyc, TMO);
      check("timeout_err", n_err - e0, 1);
      check("timeout_nodone", n_done - d0, 0);
      check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    end else begin
      check("nack_bits", dev_bits, model_frame(b));
      check("nack_err", n_err - e0, 1);
      check("nack_nodone", n_done - d0, 0);
    end
    $display("frame mode=%0d byte=%02h half=%0d bits=%03h done=%0d err=%0d",
             mode, b, h, dev_bits, n_done - d0, n_err - e0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, f0, h;
    logic [7:0] rb;

    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    $display("reset ready=%0b busy=%0b oe=%0b%0b", tx_ready, busy, ps2_clk_oe, ps2_data_oe);

    // Hand-computed frames pin the model: 0xED parity 1, 0x07 parity 0, 0x00 parity 1
    run_frame(8'hED, 0);
    check("lit_ED", dev_bits, 11'h7DA);
    run_frame(8'h07, 0);
    check("lit_07", dev_bits, 11'h40E);
    run_frame(8'h00, 0);
    check("lit_00", dev_bits, 11'h600);

    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      run_frame(rb, 0);
    end

    // Device never clocks; then device withholds ACK
    run_frame(8'h3C, 1);
    run_frame(8'h96, 2);

    // Reset in the middle of the 5th data bit
    d0 = n_done;
    e0 = n_err;
    dev_abort = 1'b0;
    fork
      send_byte(8'hA5);
      device(0, 20);
      begin
        int k;
        k = 0;
        while (dev_idx != 5 && k < 3000) begin
          @(negedge clk);
          k++;
        end
        check("reach_bit5", dev_idx, 5);
        dev_abort = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      end
    join
    repeat (10) @(negedge clk);
    dev_abort = 1'b0;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    check("midrst_nodone", n_done - d0, 0);
    check("midrst_noerr", n_err - e0, 0);
    check("midrst_ready", tx_ready, 1);
    $display("midframe reset at bit %0d ready=%0b", dev_idx, tx_ready);

    // 0xFF after reset, with a tx_valid pulse while busy that must be ignored
    d0 = n_done;
    e0 = n_err;
    f0 = n_frames;
    h  = $urandom_range(15, 30);
    fork
      send_byte(8'hFF);
      device(0, h);
      begin
        repeat (INH / 2) @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_ready("ff_ready", TMO + 200);
    repeat (3 * INH) @(negedge clk);
    check("ff_bits", dev_bits, model_frame(8'hFF));
    check("lit_FF", dev_bits, 11'h7FE);
    check("ff_done", n_done - d0, 1);
    check("ff_noerr", n_err - e0, 0);
    check("one_frame", n_frames - f0, 1);
    check("ff_idle", tx_ready, 1);
    $display("frame mode=0 byte=ff half=%0d bits=%03h done=%0d frames=%0d",
             h, dev_bits, n_done - d0, n_frames - f0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
